// File: rtl/fir_pkg.sv
// Shared definitions for the 41-tap FIR filter and its coefficient loader.
//   NUM_TAPS  taps per coefficient set
//   COEFF_W   coefficient width (filter new_coeff port)
//   SEL_W     tap index width (filter coeff_sel port), 2**SEL_W >= NUM_TAPS
package fir_pkg;

  localparam int NUM_TAPS = 41;
  localparam int COEFF_W  = 16;
  localparam int SEL_W    = 6;

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [SEL_W-1:0]   sel_t;

  // Index of the final tap; used both to spot the last beat and the last write.
  localparam sel_t LAST_TAP = sel_t'(NUM_TAPS - 1);

  // Loader FSM encoding, kept as explicit 2-bit values for older consumers.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } loader_state_t;

endpackage

// File: rtl/fir_coeff_buf.sv
// Shadow coefficient buffer: NUM_TAPS x COEFF_W register file.
//   clk      rising-edge clock
//   wr_en    write strobe (one coefficient per cycle while filling)
//   wr_addr  tap index written
//   wr_data  coefficient written
//   rd_addr  tap index read
//   rd_data  combinational read data (registered by the loader)
module fir_coeff_buf
  import fir_pkg::*;
(
  input  logic               clk,
  input  logic               wr_en,
  input  logic [SEL_W-1:0]   wr_addr,
  input  logic [COEFF_W-1:0] wr_data,
  input  logic [SEL_W-1:0]   rd_addr,
  output logic [COEFF_W-1:0] rd_data
);

  coeff_t mem [NUM_TAPS];

  // NOTE: storage arrays get no reset; every entry is written before it is
  // read, and a reset would turn a plain register file into a wide reset tree.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the 41-tap FIR filter. Collects a coefficient set
// from a valid/ready stream into a shadow buffer, checks its length, and only
// then writes the whole set to the filter one tap per clock.
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   start         one-cycle request to begin loading a set (IDLE only)
//   abort         drop the set being filled/drained (ignored in COMMIT)
//   s_valid/s_ready/s_data/s_last   coefficient stream, beat k -> tap k
//   coeff_update/coeff_sel/new_coeff   filter write port, one tap per cycle
//   busy          high from accepted start until done/err
//   done          one-cycle pulse: full set committed
//   err           one-cycle pulse: set rejected (wrong length or abort)
module fir_coeff_loader
  import fir_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [COEFF_W-1:0] s_data,
  input  logic               s_last,
  output logic               coeff_update,
  output logic [SEL_W-1:0]   coeff_sel,
  output logic [COEFF_W-1:0] new_coeff,
  output logic               busy,
  output logic               done,
  output logic               err
);

  loader_state_t state, state_nxt;
  sel_t          cnt, cnt_nxt;
  sel_t          sel_nxt, rd_addr;
  coeff_t        rd_data, coeff_nxt;
  logic          upd_nxt, done_nxt, err_nxt;
  logic          accept, last_tap, wr_en;

  assign accept   = s_valid && s_ready;
  assign last_tap = (cnt == LAST_TAP);
  assign wr_en    = accept && (state == ST_FILL);

  fir_coeff_buf u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cnt),
    .wr_data (s_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    upd_nxt   = 1'b0;
    sel_nxt   = '0;
    rd_addr   = '0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // start beats abort here; stray beats are not accepted (s_ready=0).
        if (start) begin
          state_nxt = ST_FILL;
          cnt_nxt   = '0;
        end
      end

      ST_FILL: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end else if (accept) begin
          cnt_nxt = cnt + 1'b1;
          if (last_tap && s_last) begin
            // Last beat lands this edge; the first write (tap 0) is staged now.
            state_nxt = ST_COMMIT;
            cnt_nxt   = '0;
            upd_nxt   = 1'b1;
          end else if (last_tap) begin
            state_nxt = ST_DRAIN;  // too long: swallow the rest of the set
          end else if (s_last) begin
            state_nxt = ST_IDLE;   // too short
            err_nxt   = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (abort || (accept && s_last)) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end

      ST_COMMIT: begin
        // cnt is the tap on the port this cycle; stage the following one.
        if (last_tap) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
          upd_nxt = 1'b1;
          sel_nxt = cnt + 1'b1;
          rd_addr = cnt + 1'b1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Forward the incoming beat if the tap being staged is written this same
  // edge (only possible for a one-tap set).
  always_comb begin
    coeff_nxt = '0;
    if (upd_nxt) begin
      coeff_nxt = (wr_en && (cnt == rd_addr)) ? s_data : rd_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      coeff_update <= 1'b0;
      coeff_sel    <= '0;
      new_coeff    <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      s_ready      <= (state_nxt == ST_FILL) || (state_nxt == ST_DRAIN);
      busy         <= (state_nxt != ST_IDLE);
      done         <= done_nxt;
      err          <= err_nxt;
      coeff_update <= upd_nxt;
      coeff_sel    <= sel_nxt;
      new_coeff    <= coeff_nxt;
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader. Stimulus pushes expected filter
// writes and done/err events into queues; a negedge monitor pops and compares
// whenever the DUT presents a write or an event.
module tb_fir_coeff_loader;
  import fir_pkg::*;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start, abort, s_valid, s_last;
  logic         s_ready, coeff_update, busy, done, err;
  coeff_t       s_data, new_coeff;
  sel_t         coeff_sel;

  fir_coeff_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .coeff_update (coeff_update),
    .coeff_sel    (coeff_sel),
    .new_coeff    (new_coeff),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    sel_t   sel;
    coeff_t data;
  } wr_t;
  typedef enum logic { EV_DONE, EV_ERR } ev_e;

  wr_t exp_wr[$];
  ev_e exp_ev[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  writes_seen = 0;
  int  done_cyc = -1;
  int  err_cyc  = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every write and every done/err pulse against the queues.
  always @(negedge clk) begin
    if (reset) begin
      if (coeff_update) begin
        if (exp_wr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: sel=%0d data=0x%0h, no write expected", coeff_sel, new_coeff);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("write_sel", 64'(coeff_sel), 64'(e.sel));
          check("write_data", 64'(new_coeff), 64'(e.data));
          writes_seen++;
        end
      end
      if (done || err) begin
        check("done_err_exclusive", 64'(done && err), 64'd0);
        if (exp_ev.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: done=%0b err=%0b, no event expected", done, err);
        end else begin
          ev_e ev;
          ev = exp_ev.pop_front();
          check("event_is_done", 64'(done), 64'(ev == EV_DONE));
        end
        if (done) done_cyc = cyc;
        if (err)  err_cyc  = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic with_abort);
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic expect_full(input coeff_t base, input logic fixed);
    for (int t = 0; t < NUM_TAPS; t++) begin
      exp_wr.push_back('{sel: sel_t'(t), data: fixed ? base : coeff_t'(int'(base) + t)});
    end
    exp_ev.push_back(EV_DONE);
  endtask

  // Sends n beats (s_last on beat last_idx), gap idle cycles between beats.
  // abort_at >= 0 presents that beat together with abort and stops there.
  // last_cyc: cycle in which the final beat was presented and accepted.
  task automatic send_set(input int n, input int last_idx, input coeff_t base,
                          input logic fixed, input int gap, input int abort_at,
                          output int last_cyc, output int stalls);
    last_cyc = -1;
    stalls   = 0;
    for (int k = 0; k < n; k++) begin
      int bound;
      s_valid = 1'b1;
      s_data  = fixed ? base : coeff_t'(int'(base) + k);
      s_last  = (k == last_idx);
      if (k == abort_at) begin
        abort = 1'b1;
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        break;
      end
      bound = 0;
      while (!s_ready && bound < 50) begin
        stalls++;
        bound++;
        tick();
      end
      if (!s_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_accept_timeout: beat %0d never accepted", k);
        s_valid = 1'b0;
        s_last  = 1'b0;
        break;
      end
      last_cyc = cyc;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (k != n - 1) repeat (gap) tick();
    end
  endtask

  task automatic wait_drain(input string name);
    int bound = 0;
    while ((exp_wr.size() != 0 || exp_ev.size() != 0) && bound < 300) begin
      bound++;
      tick();
    end
    check(name, 64'(exp_wr.size() + exp_ev.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({s_ready, coeff_update, busy, done, err, coeff_sel, new_coeff}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lc, st, lc2, ws0;
    start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    #2 reset = 1'b0;
    #10;
    check_reset_outputs("reset_state");
    tick();
    reset = 1'b1;
    tick();

    // Beats offered in IDLE are ignored.
    s_valid = 1'b1; s_last = 1'b1; s_data = 16'h1234;
    repeat (3) tick();
    check("idle_ready_low", 64'(s_ready), 64'd0);
    check("idle_busy_low", 64'(busy), 64'd0);
    s_valid = 1'b0; s_last = 1'b0;

    // Nominal set: 16'h0100 + k.
    expect_full(16'h0100, 1'b0);
    do_start(1'b0);
    check("start_busy", 64'(busy), 64'd1);
    check("start_ready", 64'(s_ready), 64'd1);
    send_set(41, 40, 16'h0100, 1'b0, 0, -1, lc, st);
    check("commit_ready_low", 64'(s_ready), 64'd0);
    wait_drain("nominal_drain");
    check("nominal_done_latency", 64'(done_cyc - lc), 64'(NUM_TAPS + 1));
    check("nominal_busy_after", 64'(busy), 64'd0);

    // Short set: 21 beats.
    exp_ev.push_back(EV_ERR);
    do_start(1'b0);
    send_set(21, 20, 16'h0a00, 1'b0, 0, -1, lc, st);
    wait_drain("short_drain");
    check("short_err_timing", 64'(err_cyc - lc), 64'd1);
    check("short_busy_after", 64'(busy), 64'd0);
    check("short_ready_after", 64'(s_ready), 64'd0);

    // Long set: 45 beats, extra beats drained without stalling.
    exp_ev.push_back(EV_ERR);
    do_start(1'b0);
    send_set(45, 44, 16'h0b00, 1'b0, 0, -1, lc, st);
    check("long_no_stall", 64'(st), 64'd0);
    wait_drain("long_drain");
    check("long_err_timing", 64'(err_cyc - lc), 64'd1);
    check("long_busy_after", 64'(busy), 64'd0);

    // Gapped set of 16'hffff, then back-to-back start (with abort) on done.
    expect_full(16'hffff, 1'b1);
    do_start(1'b0);
    send_set(41, 40, 16'hffff, 1'b1, 2, -1, lc, st);
    repeat (NUM_TAPS) tick();
    check("gap_done_now", 64'(done), 64'd1);
    expect_full(16'h0200, 1'b0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("gap_done_latency", 64'(done_cyc - lc), 64'(NUM_TAPS + 1));
    check("b2b_start_taken", 64'(s_ready), 64'd1);
    send_set(41, 40, 16'h0200, 1'b0, 0, -1, lc2, st);
    wait_drain("b2b_drain");
    check("b2b_done_latency", 64'(done_cyc - lc2), 64'(NUM_TAPS + 1));

    // Abort at beat 10, then an abort (and start) in COMMIT that are ignored.
    exp_ev.push_back(EV_ERR);
    do_start(1'b0);
    send_set(41, 40, 16'h0300, 1'b0, 0, 10, lc, st);
    wait_drain("abort_drain");
    check("abort_busy_after", 64'(busy), 64'd0);
    expect_full(16'h0400, 1'b0);
    do_start(1'b0);
    send_set(41, 40, 16'h0400, 1'b0, 0, -1, lc, st);
    repeat (4) tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    wait_drain("commit_abort_drain");
    check("commit_abort_done_latency", 64'(done_cyc - lc), 64'(NUM_TAPS + 1));

    // Reset asserted while write 15 is on the port.
    expect_full(16'h0500, 1'b0);
    ws0 = writes_seen;
    do_start(1'b0);
    send_set(41, 40, 16'h0500, 1'b0, 0, -1, lc, st);
    begin
      int bound = 0;
      while (writes_seen < ws0 + 15 && bound < 100) begin
        bound++;
        tick();
      end
    end
    check("pre_reset_sel", 64'(coeff_sel), 64'd15);
    #2 reset = 1'b0;
    exp_wr.delete();
    exp_ev.delete();
    #1;
    check_reset_outputs("async_reset_outputs");
    tick();
    tick();
    check("reset_writes_stopped", 64'(writes_seen - ws0), 64'd15);
    reset = 1'b1;
    tick();
    expect_full(16'h0600, 1'b0);
    do_start(1'b0);
    send_set(41, 40, 16'h0600, 1'b0, 0, -1, lc, st);
    wait_drain("post_reset_drain");
    check("post_reset_done_latency", 64'(done_cyc - lc), 64'(NUM_TAPS + 1));

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
Upstream coefficient stage for the 41-tap FIR filter. It accepts a coefficient set as a valid/ready stream into an internal shadow buffer. It checks the set length against NUM_TAPS, then commits the whole set to the filter's coeff_update/coeff_sel/new_coeff port, one tap per clock. A partial or malformed set never reaches the filter.

Parameters:
NUM_TAPS, 41, number of filter taps / coefficients per set
COEFF_W, 16, coefficient width (matches filter new_coeff)
SEL_W, 6, tap index width (matches filter coeff_sel); must satisfy 2**SEL_W >= NUM_TAPS

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin loading a new set
abort  in  1  discard the set in progress (ignored during COMMIT)
s_valid  in  1  coefficient beat valid
s_ready  out  1  loader accepts beat
s_data  in  COEFF_W  coefficient value; beat k loads tap k
s_last  in  1  marks final beat of the set
coeff_update  out  1  write strobe to filter, one tap per cycle
coeff_sel  out  SEL_W  tap index for write
new_coeff  out  COEFF_W  coefficient value for write
busy  out  1  high from start accepted until done/err
done  out  1  one-cycle pulse: full set committed
err  out  1  one-cycle pulse: set rejected (length mismatch or abort)

Behaviour:
- Reset (reset=0, async): state IDLE, tap counter 0. Outputs: s_ready, coeff_update, busy, done, err = 0; coeff_sel = 0; new_coeff = 0. Shadow buffer contents are not reset.
- All outputs are registered. A beat is accepted on a rising edge with s_valid && s_ready.
- States: IDLE, FILL, DRAIN, COMMIT.
- IDLE: s_ready=0. start=1 moves to FILL next cycle; busy rises on the same edge; counter clears. s_valid in IDLE is ignored.
- FILL: s_ready=1. Each accepted beat writes buf[cnt] = s_data, then cnt++.
  - Beat with cnt == NUM_TAPS-1 and s_last=1: go to COMMIT.
  - Beat with cnt == NUM_TAPS-1 and s_last=0: go to DRAIN (set too long).
  - Beat with s_last=1 and cnt < NUM_TAPS-1: go to IDLE; err pulses; busy drops (set too short).
- DRAIN: s_ready=1. Beats are consumed and discarded until a beat with s_last=1. Then go to IDLE; err pulses; busy drops.
- COMMIT: s_ready=0. coeff_update=1 for exactly NUM_TAPS consecutive cycles, starting the cycle after the last beat is accepted. coeff_sel steps 0,1,...,NUM_TAPS-1 and new_coeff = buf[coeff_sel], both aligned with coeff_update.
  - The cycle after the final write: coeff_update=0, coeff_sel=0, new_coeff=0, done=1 for one cycle, busy=0, state IDLE.
  - Latency from last accepted beat to done is NUM_TAPS+1 cycles.
- abort: in FILL or DRAIN, go to IDLE next cycle; err pulses; busy drops; no filter writes. Ignored in IDLE and COMMIT, so a commit is never partial except by reset.
- start while not IDLE: ignored. Simultaneous start and abort in IDLE: start wins, abort ignored.
- done and err are never high in the same cycle.
- Reset asserted mid-COMMIT: writes stop immediately and the filter holds a partially updated set. The system controller must reload after reset.
- Back-to-back sets: a new start is accepted in the cycle done or err is high (the loader is already in IDLE), so there are zero dead cycles.

Decomposition:
- Shared package fir_pkg holds NUM_TAPS, COEFF_W, SEL_W localparams, the coeff_t typedef (logic [COEFF_W-1:0]), and the loader state enum. The filter and loader both import it.
- Sub-module fir_coeff_buf: NUM_TAPS x COEFF_W register file with one synchronous write port (FILL) and one read port (COMMIT). Its read is combinational, so new_coeff is registered in the loader.

Test Plan:
- Nominal: start, then 41 beats of value 16'h0100+k with s_last on beat 40. Required: coeff_update high 41 consecutive cycles, coeff_sel 0..40, new_coeff 16'h0100..16'h0128; done one cycle later; err never high.
- Short set: s_last on beat 20 (21 beats). Required: err pulse the cycle after beat 20; coeff_update never asserts; busy low afterwards.
- Long set: 45 beats, s_last on beat 44. Required: s_ready stays high through beat 44 (DRAIN); err pulse after beat 44; no filter writes.
- Backpressure/gaps: s_valid toggled 1,0,0,1,... through a 41-beat set of 16'hffff. Required: every write is 16'hffff; done arrives exactly 42 cycles after the last accepted beat.
- Abort: abort at beat 10 is accepted, ending the load with no writes and err high. A second abort pulsed at the 5th COMMIT cycle of a following valid set is ignored: 41 writes complete and done fires.
- Reset: reset low at COMMIT write 15. Required: coeff_update, busy, s_ready drop asynchronously and all outputs sit at reset values. After release, start plus a full set commits normally.
